mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single instruction/data memory read port between two requesters: port 0 is the instruction-cache refill engine (NUM_BLOCKS-beat line fills), port 1 is the data/decompressor read path (single beats).
- Uses round-robin arbitration with burst locking. A granted requester keeps the port across the idle gap between consecutive refill beats, so one line fill is never interleaved.
- Sits between the cache/decompressor masters and the memory model. It uses the same valid/ready/rdata read handshake on both sides.

Parameters:
- DATA_W, 32, width of read data per beat.
- P0_BEATS, 4, beats per locked burst on port 0 (equals cache NUM_BLOCKS).
- P1_BEATS, 1, beats per locked burst on port 1.
- HOLD_CYCLES, 2, cycles the owner may leave valid low mid-burst before the lock is released.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- p0_req_valid  in  1  port 0 read request
- p0_req_ready  out  1  port 0 beat complete (one-cycle pulse)
- p0_req_addr  in  32  port 0 word address
- p0_req_rdata  out  DATA_W  port 0 read data, valid when p0_req_ready
- p1_req_valid, p1_req_ready, p1_req_addr, p1_req_rdata  same as port 0 for port 1
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory beat complete, rdata valid
- mem_req_addr  out  32  address to memory
- mem_req_rdata  in  DATA_W  memory read data
- owner  out  2  debug: bit0 = locked, bit1 = owning port

Behaviour:
- Handshake on every interface: the master holds valid and addr until ready. Ready is a one-cycle pulse carrying rdata. The master may drop valid in the cycle after ready.
- State register with values IDLE and LOCKED. Registers: own (1b), beat_cnt (3b, saturating at 7 and compared against the owner's beat limit), hold_cnt (sized for HOLD_CYCLES), rr_ptr (1b, the port with priority).
- Reset (async, any cycle, including mid-beat): state = IDLE, own = 0, beat_cnt = 0, hold_cnt = 0, rr_ptr = 0. Reset takes effect immediately: mem_req_valid = 0, both p*_req_ready = 0, rdata outputs = 0, owner = 0. Memory must tolerate valid dropping without ready.
- IDLE:
  - No grant and no forwarding.
  - If exactly one p*_req_valid is high, go to LOCKED with own = that port on the next edge.
  - If both are high, own = rr_ptr.
  - Grant latency is 1 cycle from valid to mem_req_valid.
- LOCKED, forwarding path (combinational from own):
  - mem_req_valid = p[own]_req_valid.
  - mem_req_addr = p[own]_req_addr; 0 when not forwarding.
  - p[own]_req_ready = mem_req_ready.
  - p[own]_req_rdata = mem_req_rdata.
  - The non-owner sees ready = 0 and rdata = 0.
- LOCKED, beat accounting:
  - Each mem_req_ready increments beat_cnt and clears hold_cnt.
  - On the beat where beat_cnt+1 == beats(own): next state IDLE, beat_cnt = 0, rr_ptr = ~own.
- LOCKED, hold timer:
  - A cycle with p[own]_req_valid = 0 and no ready increments hold_cnt.
  - When hold_cnt reaches HOLD_CYCLES: release early to IDLE, beat_cnt = 0, rr_ptr = ~own. This is how an aborted refill is handled.
  - Owner valid high without ready leaves hold_cnt unchanged.
- Simultaneous events:
  - Release and the other port's valid in the same cycle: the other port is granted on the following edge through IDLE. Minimum 1 IDLE cycle between owners.
  - mem_req_ready while the owner's valid is low is a memory protocol error. The arbiter ignores it: not forwarded, not counted.
- Starvation bound: after any release the waiting port has priority, so a port waits at most one full burst plus HOLD_CYCLES plus 1 cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding ST_IDLE/ST_LOCKED
  - port index constants PORT_ICACHE = 0, PORT_DATA = 1
  - beat-limit function beats(port) returning P0_BEATS or P1_BEATS
- One sub-module, rr_pick2: combinational 2-way round-robin pick (inputs req[1:0] and rr_ptr, outputs gnt_valid and gnt_idx).
- All state lives in mem_port_arbiter.

Test Plan:
- Port 0 only, 4 beats, memory gives ready 2 cycles after each valid, 1-cycle valid gap between beats:
  - addresses 0x100, 0x104, 0x108, 0x10C forwarded in order;
  - 4 ready pulses reach port 0 only;
  - IDLE after the 4th beat; rr_ptr = 1.
- Both ports assert valid at the same cycle after reset:
  - port 0 granted first (rr_ptr = 0);
  - port 1's address 0x2000 appears on mem_req_addr only after port 0's 4th ready plus 1 IDLE cycle.
- Port 1 requests during port 0's mid-burst gap (valid low 1 cycle):
  - no interleave, lock held;
  - port 1 is served after port 0 completes.
- Port 0 drops valid after beat 2 and stays low:
  - release after HOLD_CYCLES = 2 idle cycles;
  - a pending port 1 is granted the next cycle;
  - beat_cnt is back at 0.
- Reset asserted while mem_req_valid = 1 mid-beat:
  - mem_req_valid and both readys are 0 in the same cycle, without waiting for clk;
  - owner = 0;
  - after deassertion a fresh port 1 request is granted with 1-cycle latency.
- Spurious mem_req_ready with owner valid low:
  - no ready pulse on either port;
  - beat_cnt unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg
// Shared definitions for the instruction/data memory read-port arbiter:
// arbiter state encoding, requester port indices, default sizing and the
// per-port burst length helper.
package mem_arb_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int P0_BEATS_DEF    = 4;
  localparam int P1_BEATS_DEF    = 1;
  localparam int HOLD_CYCLES_DEF = 2;

  // Port 0 is the icache refill engine, port 1 the data/decompressor path.
  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Number of beats a port keeps the memory locked for.
  function automatic int beats(input logic port, input int p0_beats, input int p1_beats);
    return (port == PORT_DATA) ? p1_beats : p0_beats;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// valid/ready/rdata read handshake used on both arbiter sides.
//   valid : master holds a read request (addr stable until ready)
//   addr  : 32-bit word address
//   ready : one-cycle pulse, beat complete, rdata valid
//   rdata : read data for the beat
// master modport drives valid/addr, slave modport drives ready/rdata.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              valid;
  logic [31:0]       addr;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, output addr, input ready, input rdata);
  modport slave  (input valid, input addr, output ready, output rdata);

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin pick.
//   req[1:0]  : pending requests per port
//   rr_ptr    : port that wins when both request
//   gnt_valid : at least one port requests
//   gnt_idx   : chosen port
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // A lone requester always wins; a tie goes to the priority pointer.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = PORT_ICACHE;
    if (req[PORT_DATA] && req[PORT_ICACHE]) begin
      gnt_idx = rr_ptr;
    end else if (req[PORT_DATA]) begin
      gnt_idx = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory read port between the icache refill engine (p0,
// multi-beat line fills) and the data/decompressor path (p1, single beats).
// Round-robin between ports with burst locking: the owner keeps the port
// across short valid gaps so a line fill is never interleaved.
//   clk, reset : clock, asynchronous active-high reset
//   p0, p1     : requester sides (slave modport)
//   mem        : memory side (master modport)
//   owner      : debug, bit0 = locked, bit1 = owning port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int P0_BEATS    = P0_BEATS_DEF,
  parameter int P1_BEATS    = P1_BEATS_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    p0,
  mem_port_arbiter_if.slave    p1,
  mem_port_arbiter_if.master   mem,
  output logic [1:0]           owner
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  arb_state_e        state_q, state_d;
  logic              own_q, own_d;
  logic [2:0]        beat_q, beat_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rr_q, rr_d;

  logic        locked;
  logic        own_valid;
  logic [31:0] own_addr;
  logic        fwd;
  logic        beat_done;
  logic        gnt_valid;
  logic        gnt_idx;

  rr_pick2 u_pick (
    .req       ({p1.valid, p0.valid}),
    .rr_ptr    (rr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Forwarding path: only the owner's request reaches memory, and a memory
  // ready seen while the owner's valid is low is never passed on.
  assign locked    = (state_q == ST_LOCKED);
  assign own_valid = (own_q == PORT_DATA) ? p1.valid : p0.valid;
  assign own_addr  = (own_q == PORT_DATA) ? p1.addr : p0.addr;
  assign fwd       = locked && own_valid;
  assign beat_done = fwd && mem.ready;

  assign mem.valid = fwd;
  assign mem.addr  = fwd ? own_addr : 32'd0;

  assign p0.ready  = beat_done && (own_q == PORT_ICACHE);
  assign p1.ready  = beat_done && (own_q == PORT_DATA);
  assign p0.rdata  = (locked && (own_q == PORT_ICACHE)) ? mem.rdata : '0;
  assign p1.rdata  = (locked && (own_q == PORT_DATA)) ? mem.rdata : '0;

  assign owner     = {locked & own_q, locked};

  // Next-state logic: grant from IDLE, then count beats and idle-valid
  // cycles while locked. Both the last beat and an expired hold timer
  // release the port and hand priority to the other requester.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = ST_LOCKED;
          own_d   = gnt_idx;
          beat_d  = 3'd0;
          hold_d  = '0;
        end
      end
      ST_LOCKED: begin
        if (beat_done) begin
          hold_d = '0;
          if (int'(beat_q) + 1 == beats(own_q, P0_BEATS, P1_BEATS)) begin
            state_d = ST_IDLE;
            beat_d  = 3'd0;
            rr_d    = ~own_q;
          end else if (beat_q != 3'd7) begin
            beat_d = beat_q + 3'd1;
          end
        end else if (!own_valid) begin
          if (int'(hold_q) + 1 == HOLD_CYCLES) begin
            state_d = ST_IDLE;
            beat_d  = 3'd0;
            hold_d  = '0;
            rr_d    = ~own_q;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset clears everything at once so the memory request
  // and both readys drop without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      own_q   <= PORT_ICACHE;
      beat_q  <= 3'd0;
      hold_q  <= '0;
      rr_q    <= PORT_ICACHE;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      beat_q  <= beat_d;
      hold_q  <= hold_d;
      rr_q    <= rr_d;
    end
  end

endmodule
